// File: rtl/noise_env_ctrl_pkg.sv
// Shared types and helpers for the noise channel envelope/rate controller.
// Holds the envelope state encodings, amplitude ceiling and saturating arithmetic.
package noise_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_t;

    localparam logic [6:0] AMP_MAX     = 7'd127;
    localparam int         RATE_W_DEF  = 16;
    localparam int         ENV_DIV_DEF = 1000;

    function automatic logic [6:0] sat_add(input logic [6:0] a, input logic [6:0] b);
        logic [7:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[7] ? AMP_MAX : sum[6:0];
    endfunction

    // Subtract b from a but never go below floor; the limit is summed 8 bits wide.
    function automatic logic [6:0] sat_sub_floor(input logic [6:0] a, input logic [6:0] b,
                                                 input logic [6:0] floor);
        logic [7:0] lim;
        lim = {1'b0, floor} + {1'b0, b};
        return ({1'b0, a} <= lim) ? floor : (a - b);
    endfunction

endpackage

// File: rtl/noise_env_ctrl_if.sv
// Control/status bundle between the note logic (master) and the noise envelope controller (slave).
// The release rate is named rel because release is a reserved word.
interface noise_env_ctrl_if #(
    parameter int RATE_W = 16
);
    logic              gate;
    logic [RATE_W-1:0] rate;
    logic [6:0]        attack;
    logic [6:0]        decay;
    logic [6:0]        sustain;
    logic [6:0]        rel;
    logic              step;
    logic [6:0]        amplitude;
    logic [2:0]        state;

    modport master (
        output gate, rate, attack, decay, sustain, rel,
        input  step, amplitude, state
    );

    modport slave (
        input  gate, rate, attack, decay, sustain, rel,
        output step, amplitude, state
    );
endinterface

// File: rtl/noise_env_ctrl_step_timer.sv
// Rate divider producing the one-cycle LFSR advance pulse every rate+1 enabled clocks.
// The count holds while disabled so the noise register stays frozen in IDLE.
module noise_step_timer #(
    parameter int RATE_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [RATE_W-1:0] rate,
    output logic              step
);

    logic [RATE_W-1:0] cnt;

    // Using >= lets a lowered rate fire on the very next cycle instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            step <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            step <= 1'b0;
        end else if (en) begin
            if (cnt >= rate) begin
                cnt  <= '0;
                step <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                step <= 1'b0;
            end
        end else begin
            step <= 1'b0;
        end
    end

endmodule

// File: rtl/noise_env_ctrl.sv
// ADSR envelope and LFSR step-rate controller for the noise voice.
// Amplitude only moves on envelope ticks; gate edges and gate-low act every cycle.
module noise_env_ctrl
    import noise_ctrl_pkg::*;
#(
    parameter int RATE_W  = RATE_W_DEF,
    parameter int ENV_DIV = ENV_DIV_DEF
) (
    input logic                   clk,
    input logic                   rst,
    noise_env_ctrl_if.slave       bus
);

    localparam int TW = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;

    env_state_t  st;
    logic [6:0]  amp;
    logic [TW-1:0] tick_cnt;
    logic [TW-1:0] next_tick;
    logic        gate_d;
    logic        rise;
    logic        tick;
    logic        held_state;
    logic        step_pulse;
    logic [6:0]  attack_nxt;
    logic [6:0]  decay_nxt;
    logic [6:0]  release_nxt;

    assign rise       = bus.gate & ~gate_d;
    assign tick       = (st != ST_IDLE) && (tick_cnt == TW'(ENV_DIV - 1));
    assign next_tick  = tick ? '0 : tick_cnt + 1'b1;
    assign held_state = (st == ST_ATTACK) || (st == ST_DECAY) || (st == ST_SUSTAIN);

    assign attack_nxt  = (bus.attack == 7'd0) ? AMP_MAX : sat_add(amp, bus.attack);
    assign decay_nxt   = (bus.decay == 7'd0) ? bus.sustain
                                             : sat_sub_floor(amp, bus.decay, bus.sustain);
    assign release_nxt = (bus.rel == 7'd0) ? 7'd0 : sat_sub_floor(amp, bus.rel, 7'd0);

    // A retrigger keeps the current amplitude so re-keying a releasing voice does not click.
    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= ST_IDLE;
            amp      <= '0;
            tick_cnt <= '0;
            gate_d   <= 1'b0;
        end else begin
            gate_d <= bus.gate;
            if (rise) begin
                st       <= ST_ATTACK;
                tick_cnt <= '0;
            end else if (st == ST_IDLE) begin
                amp <= '0;
            end else if (st > ST_RELEASE) begin
                st       <= ST_IDLE;
                amp      <= '0;
                tick_cnt <= '0;
            end else if (!bus.gate && held_state) begin
                st       <= ST_RELEASE;
                tick_cnt <= next_tick;
            end else begin
                tick_cnt <= next_tick;
                if (tick) begin
                    case (st)
                        ST_ATTACK: begin
                            amp <= attack_nxt;
                            if (attack_nxt == AMP_MAX) st <= ST_DECAY;
                        end
                        ST_DECAY: begin
                            amp <= decay_nxt;
                            if (decay_nxt == bus.sustain) st <= ST_SUSTAIN;
                        end
                        ST_SUSTAIN: amp <= bus.sustain;
                        ST_RELEASE: begin
                            amp <= release_nxt;
                            if (release_nxt == 7'd0) st <= ST_IDLE;
                        end
                        default: begin
                            st  <= ST_IDLE;
                            amp <= '0;
                        end
                    endcase
                end
            end
        end
    end

    noise_step_timer #(
        .RATE_W (RATE_W)
    ) u_step_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (st != ST_IDLE),
        .clr  (rise && (st == ST_IDLE)),
        .rate (bus.rate),
        .step (step_pulse)
    );

    assign bus.step      = step_pulse;
    assign bus.amplitude = amp;
    assign bus.state     = st;

endmodule

// File: tb/tb_noise_env_ctrl.sv
// Directed bench for noise_env_ctrl with ENV_DIV=4; expected values are hand-computed.
// Inputs change and outputs are sampled on the falling edge.
module tb_noise_env_ctrl;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    noise_env_ctrl_if #(.RATE_W(16)) bus ();

    noise_env_ctrl #(
        .RATE_W  (16),
        .ENV_DIV (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance until step is seen, bounded; a timeout counts as a failed check.
    task automatic wait_for_step(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.step && n < 20);
        check_output(tag, int'(bus.step), 1);
    endtask

    initial begin
        int exp_amp [8];
        int n;
        int cnt;
        exp_amp = '{32, 64, 96, 127, 111, 95, 79, 64};
        errors = 0;
        checks = 0;

        // Reset and idle
        rst = 1'b1;
        bus.gate = 1'b0;
        bus.rate = 16'd2;
        bus.attack = 7'd0;
        bus.decay = 7'd0;
        bus.sustain = 7'd0;
        bus.rel = 7'd0;
        wait_cycles(3);
        check_output("reset_amp", int'(bus.amplitude), 0);
        check_output("reset_state", int'(bus.state), 0);
        check_output("reset_step", int'(bus.step), 0);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 500; i++) begin
            wait_cycles(1);
            if (bus.step || bus.amplitude != 7'd0 || bus.state != 3'd0) cnt++;
        end
        check_output("idle_quiet", cnt, 0);

        // Full envelope
        bus.attack = 7'd32;
        bus.decay = 7'd16;
        bus.sustain = 7'd64;
        bus.rate = 16'd2;
        bus.gate = 1'b1;
        wait_cycles(1);
        check_output("env_attack_state", int'(bus.state), 1);
        check_output("env_attack_amp0", int'(bus.amplitude), 0);
        wait_cycles(2);
        check_output("first_step_early", int'(bus.step), 0);
        wait_cycles(1);
        check_output("env_latency_amp", int'(bus.amplitude), 0);
        check_output("first_step", int'(bus.step), 1);
        wait_cycles(1);
        check_output("env_tick1", int'(bus.amplitude), exp_amp[0]);
        for (int i = 1; i < 8; i++) begin
            wait_cycles(4);
            check_output($sformatf("env_tick%0d", i + 1), int'(bus.amplitude), exp_amp[i]);
            if (i == 3) check_output("env_decay_state", int'(bus.state), 2);
        end
        check_output("env_sustain_state", int'(bus.state), 3);
        wait_cycles(8);
        check_output("env_sustain_hold", int'(bus.amplitude), 64);
        check_output("env_sustain_state2", int'(bus.state), 3);

        // Step rate
        wait_for_step("rate2_find");
        wait_cycles(1);
        check_output("rate2_gap1", int'(bus.step), 0);
        wait_cycles(1);
        check_output("rate2_gap2", int'(bus.step), 0);
        wait_cycles(1);
        check_output("rate2_third", int'(bus.step), 1);
        bus.rate = 16'd0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            wait_cycles(1);
            if (bus.step) cnt++;
        end
        check_output("rate0_every", cnt, 6);
        bus.rate = 16'd5;
        wait_for_step("rate5_find");
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            wait_cycles(1);
            if (bus.step) cnt++;
        end
        check_output("rate5_quiet", cnt, 0);
        bus.rate = 16'd1;
        wait_cycles(1);
        check_output("rate_lowered", int'(bus.step), 1);

        // Instant release
        bus.rel = 7'd0;
        bus.gate = 1'b0;
        wait_cycles(1);
        check_output("rel0_state", int'(bus.state), 4);
        n = 1;
        while (bus.state != 3'd0 && n < 8) begin
            wait_cycles(1);
            n++;
        end
        check_output("rel0_idle", int'(bus.state), 0);
        check_output("rel0_amp", int'(bus.amplitude), 0);
        check_output("rel0_latency", int'(n >= 2 && n <= 5), 1);

        // Early release
        bus.rate = 16'd2;
        bus.attack = 7'd32;
        bus.gate = 1'b1;
        wait_cycles(9);
        check_output("early_amp64", int'(bus.amplitude), 64);
        check_output("early_attack", int'(bus.state), 1);
        bus.gate = 1'b0;
        bus.rel = 7'd40;
        wait_cycles(1);
        check_output("early_rel_state", int'(bus.state), 4);
        check_output("early_rel_hold", int'(bus.amplitude), 64);
        wait_cycles(2);
        check_output("early_rel_pre", int'(bus.amplitude), 64);
        wait_cycles(1);
        check_output("early_rel_24", int'(bus.amplitude), 24);
        wait_cycles(4);
        check_output("early_rel_0", int'(bus.amplitude), 0);
        check_output("early_idle", int'(bus.state), 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            wait_cycles(1);
            if (bus.step) cnt++;
        end
        check_output("early_step_stop", cnt, 0);

        // Retrigger from release
        bus.attack = 7'd50;
        bus.rel = 7'd10;
        bus.gate = 1'b1;
        wait_cycles(5);
        check_output("retrig_amp50", int'(bus.amplitude), 50);
        bus.gate = 1'b0;
        wait_cycles(1);
        check_output("retrig_rel_state", int'(bus.state), 4);
        bus.gate = 1'b1;
        bus.attack = 7'd20;
        wait_cycles(1);
        check_output("retrig_state", int'(bus.state), 1);
        check_output("retrig_keep_amp", int'(bus.amplitude), 50);
        wait_cycles(3);
        check_output("retrig_pre_tick", int'(bus.amplitude), 50);
        wait_cycles(1);
        check_output("retrig_tick", int'(bus.amplitude), 70);

        // Reset mid-attack, retrigger on release of reset, instant attack and decay
        bus.attack = 7'd0;
        bus.decay = 7'd0;
        bus.sustain = 7'd64;
        rst = 1'b1;
        wait_cycles(1);
        check_output("rst_mid_amp", int'(bus.amplitude), 0);
        check_output("rst_mid_state", int'(bus.state), 0);
        check_output("rst_mid_step", int'(bus.step), 0);
        rst = 1'b0;
        wait_cycles(1);
        check_output("rst_retrig_state", int'(bus.state), 1);
        wait_cycles(3);
        check_output("att0_pre", int'(bus.amplitude), 0);
        wait_cycles(1);
        check_output("att0_amp", int'(bus.amplitude), 127);
        check_output("att0_state", int'(bus.state), 2);
        wait_cycles(4);
        check_output("dec0_amp", int'(bus.amplitude), 64);
        check_output("dec0_state", int'(bus.state), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/noise_env_ctrl.md
# noise_env_ctrl

Envelope and rate controller for the noise channel. It produces the one-cycle step enable that advances the noise LFSR and the 7-bit amplitude that scales its output. On each gate it runs an attack/decay/sustain/release envelope, so the noise voice behaves like a keyed instrument rather than a constant hiss. It sits between the note/control logic and the noise generator in the synth datapath.

## Interface
- RATE_W, 16, width of the LFSR step-period register
- ENV_DIV, 1000, clocks per envelope tick (≥2)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- gate  in  1  note held; level-sensitive with rising-edge retrigger
- rate  in  RATE_W  step period minus one; step pulses every rate+1 clocks
- attack  in  7  amplitude increment per envelope tick; 0 = instant
- decay  in  7  amplitude decrement per tick toward sustain; 0 = instant
- sustain  in  7  sustain level
- release  in  7  amplitude decrement per tick toward 0; 0 = instant
- step  out  1  one-cycle LFSR advance enable (drives the generator's clk_div)
- amplitude  out  7  envelope level, registered
- state  out  3  current envelope state, for debug and voice allocation

## Operation
- States and encodings: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4. Values 5–7 recover to IDLE.
- gate_d is a registered copy of gate. A rising edge is gate & ~gate_d.
- Rising edge, from any state: go to ATTACK, clear the env tick counter, and keep the current amplitude (no click on retrigger).
  - From IDLE only, the step counter is also cleared.
- gate==0 while in ATTACK, DECAY or SUSTAIN: go to RELEASE on that cycle. This is checked every cycle, not only on ticks.
- env tick: fires when the tick counter equals ENV_DIV-1, then the counter wraps to 0. The counter runs only when state≠IDLE. All amplitude changes happen only on ticks.
- ATTACK tick: amp = min(127, amp+attack), or 127 if attack==0. On the tick where amp reaches 127, go to DECAY.
- DECAY tick: amp = max(sustain, amp−decay), or sustain if decay==0. On reaching sustain, go to SUSTAIN.
  - If amp is already below sustain (sustain was raised), amp = sustain on the next tick.
- SUSTAIN tick: amp = sustain, so sustain changes take effect at tick granularity.
- RELEASE tick: amp = max(0, amp−release), or 0 if release==0. On reaching 0, go to IDLE.
- Arithmetic: sums are computed 8 bits wide and saturate. Outputs never wrap.
- Step counter, when state≠IDLE:
  - if cnt ≥ rate, then step=1 and cnt=0;
  - else cnt+1.
  - Lowering rate below the current cnt therefore fires on the next cycle.
- In IDLE: step=0, amplitude=0, and the noise register stays frozen.
- Priority on the same cycle: rst > gate rising edge > gate low > tick.

## Timing
- Reset values: amplitude=0, step=0, state=IDLE, both counters 0, gate_d=0.
- rst asserted mid-envelope returns everything to reset values on the next edge. If gate is still high when rst deasserts, gate_d=0 causes a retrigger.
- Gate rising edge sampled at edge N: state=ATTACK visible after edge N.
- First amplitude change is ENV_DIV cycles after that.
- First step is rate+1 cycles after leaving IDLE.
- amplitude and state are registered; step is a registered pulse.
- Single clock domain. gate must already be synchronous to clk.

## Structure
- Package noise_ctrl_pkg holds:
  - the state encodings (3-bit enum);
  - AMP_MAX=127;
  - the default RATE_W and ENV_DIV.
- Sub-module noise_step_timer is the rate divider. Inputs: clk, rst, en, clr, rate. Output: step.
- The envelope FSM, tick counter and saturating arithmetic live in noise_env_ctrl.

## Test plan
All tests use ENV_DIV=4.
- **Reset and idle:** rst=1 for 3 cycles, then gate=0 for 500 cycles → amplitude=0, state=0, step never asserted.
- **Full envelope:** attack=32, decay=16, sustain=64, gate held high.
  - amplitude goes 32, 64, 96, 127 on ticks 1–4, then 111, 95, 79, 64.
  - state ends at 3, and amplitude holds 64.
- **Step rate:** rate=2 with gate held → step every 3rd cycle. Change rate to 0 → step every cycle. rate=5 then rate=1 while cnt=3 → step on the next cycle.
- **Early release:** gate drops in ATTACK at amp=64 with release=40 → RELEASE on the next cycle. amplitude 24, then 0 → IDLE, and step stops.
- **Retrigger:** gate rises in RELEASE at amp=50, attack=20 → ATTACK with amp=50, first tick after 4 cycles gives 70.
- **Instant edges and reset:**
  - attack=0 → 127 on the first tick.
  - release=0 → 0 on the first tick after gate falls.
  - rst pulsed mid-ATTACK → amplitude=0 and state=IDLE after one edge.
